// File: rtl/jt49_seq_pkg.sv
// Shared definitions for the jt49 command sequencer: command op codes,
// FSM state encodings, the envelope-shape register index and the queued
// command layout.
package jt49_seq_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_WAIT  = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;
    localparam logic [1:0] OP_RSV   = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_RECOV = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Writing the envelope shape restarts the envelope, so it is never elided.
    localparam logic [3:0] ENV_SHAPE_REG = 4'd13;

    typedef struct packed {
        logic [1:0]  op;
        logic [11:0] arg;
    } seq_cmd_t;

    // Bus pin encoding {bdir,bc1} for a state; read (01) is never produced.
    function automatic logic [1:0] bus_code(input logic [2:0] st);
        case (st)
            S_ADDR:  bus_code = 2'b11;
            S_DATA:  bus_code = 2'b10;
            default: bus_code = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/jt49_seq_fifo.sv
// Single-clock synchronous command FIFO. Push and pop only take effect on
// clk_en ticks; a push while full or a pop while empty is ignored.
module jt49_seq_fifo #(
    parameter int AW = 3,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update for accepted push/pop.
    always_comb begin
        do_push  = clk_en && push && !full;
        do_pop   = clk_en && pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer registers; reset flushes the FIFO without clearing storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/jt49_cmd_seq.sv
// Register-write sequencer for jt49_bus: drains queued commands and drives
// the bdir/bc1/din pins with timed address-latch and data-write phases.
// Optional macro JT49_SEQ_SHADOW_EN keeps a shadow of written register values
// and drops writes that would not change the chip state.
//
// state | meaning
// IDLE  | pop and decode next command
// ADDR  | latch address, {bdir,bc1}=11 for HOLD ticks
// GAP   | bus inactive for one tick, din held
// DATA  | write data, {bdir,bc1}=10 for HOLD ticks
// RECOV | bus inactive for HOLD ticks
// WAIT  | bus inactive for count<<WAIT_SHIFT ticks
// DONE  | END executed, terminal until reset
module jt49_cmd_seq
    import jt49_seq_pkg::*;
#(
    parameter int HOLD       = 8,
    parameter int FIFO_AW    = 3,
    parameter int WAIT_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [11:0]        cmd_arg,
    output logic               bdir,
    output logic               bc1,
    output logic [7:0]         din,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [FIFO_AW:0]   level
);
    localparam int PCW = $clog2(HOLD) + 1;
    localparam int WCW = 8 + WAIT_SHIFT;

    logic [2:0]     state_q, state_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [3:0]     addr_q, addr_d, last_addr_q, last_addr_d;
    logic [7:0]     data_q, data_d, din_q, din_d;
    logic           last_vld_q, last_vld_d, err_q, err_d;
    logic           bdir_q, bdir_d, bc1_q, bc1_d;
    logic           pop, fifo_full, fifo_empty, shadow_hit;
    logic [13:0]    fifo_rd;
    seq_cmd_t       head;

    // Commands are only transferred on clk_en ticks, so the host shares clk_en.
    jt49_seq_fifo #(.AW(FIFO_AW), .DW(14)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .push    (cmd_valid),
        .pop     (pop),
        .wr_data ({cmd_op, cmd_arg}),
        .rd_data (fifo_rd),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head      = seq_cmd_t'(fifo_rd);
    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign bdir      = bdir_q;
    assign bc1       = bc1_q;
    assign din       = din_q;

`ifdef JT49_SEQ_SHADOW_EN
    logic [7:0]  shadow_q [16];
    logic [15:0] shadow_vld_q, shadow_vld_d;
    logic        shadow_wr;

    assign shadow_wr  = (state_d == S_DATA) && (state_q != S_DATA);
    assign shadow_hit = (head.arg[11:8] != ENV_SHAPE_REG) && shadow_vld_q[head.arg[11:8]]
                        && (shadow_q[head.arg[11:8]] == head.arg[7:0]);

    // Mark a register as known once its data phase starts.
    always_comb begin
        shadow_vld_d = shadow_vld_q;
        if (shadow_wr) shadow_vld_d[addr_d] = 1'b1;
    end

    // Shadow valid bits clear on reset so every register is written once.
    always_ff @(posedge clk) begin
        if (!rst_n) shadow_vld_q <= '0;
        else        shadow_vld_q <= shadow_vld_d;
    end

    // Shadow value storage.
    always_ff @(posedge clk) begin
        if (shadow_wr) shadow_q[addr_d] <= data_d;
    end
`else
    assign shadow_hit = 1'b0;
`endif

    // Next-state, counters and registered bus pins derived from the next state.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        err_d       = err_q;
        pop         = 1'b0;
        if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        case (head.op)
                            OP_WRITE: begin
                                if (!shadow_hit) begin
                                    addr_d = head.arg[11:8];
                                    data_d = head.arg[7:0];
                                    pcnt_d = PCW'(HOLD - 1);
                                    if (last_vld_q && (head.arg[11:8] == last_addr_q)) begin
                                        state_d = S_DATA;
                                    end else begin
                                        state_d     = S_ADDR;
                                        last_addr_d = head.arg[11:8];
                                        last_vld_d  = 1'b1;
                                    end
                                end
                            end
                            OP_WAIT: begin
                                if (head.arg[7:0] != 8'h00) begin
                                    state_d = S_WAIT;
                                    wcnt_d  = (WCW'(head.arg[7:0]) << WAIT_SHIFT) - WCW'(1);
                                end
                            end
                            OP_END:  state_d = S_DONE;
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (pcnt_q == '0) state_d = S_GAP;
                    else              pcnt_d  = pcnt_q - 1'b1;
                end
                S_GAP: begin
                    state_d = S_DATA;
                    pcnt_d  = PCW'(HOLD - 1);
                end
                S_DATA: begin
                    if (pcnt_q == '0) begin
                        state_d = S_RECOV;
                        pcnt_d  = PCW'(HOLD - 1);
                    end else begin
                        pcnt_d = pcnt_q - 1'b1;
                    end
                end
                S_RECOV: begin
                    if (pcnt_q == '0) state_d = S_IDLE;
                    else              pcnt_d  = pcnt_q - 1'b1;
                end
                S_WAIT: begin
                    if (wcnt_q == '0) state_d = S_IDLE;
                    else              wcnt_d  = wcnt_q - 1'b1;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
        {bdir_d, bc1_d} = bus_code(state_d);
        din_d = din_q;
        if (state_d == S_ADDR)      din_d = {4'h0, addr_d};
        else if (state_d == S_DATA) din_d = data_d;
    end

    // State and output registers; reset abandons any bus cycle in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pcnt_q      <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            bdir_q      <= 1'b0;
            bc1_q       <= 1'b0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
            err_q       <= err_d;
            bdir_q      <= bdir_d;
            bc1_q       <= bc1_d;
            din_q       <= din_d;
        end
    end

endmodule

// File: tb/tb_jt49_cmd_seq.sv
// Directed bench for jt49_cmd_seq (HOLD=8, FIFO_AW=3, WAIT_SHIFT=4).
module tb_jt49_cmd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [11:0] cmd_arg = 12'h000;
    logic        bdir, bc1, busy, done, err;
    logic [7:0]  din;
    logic [3:0]  level;

    int npass  = 0;
    int ntotal = 0;

    jt49_cmd_seq #(.HOLD(8), .FIFO_AW(3), .WAIT_SHIFT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .bdir      (bdir),
        .bc1       (bc1),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .level     (level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until the handshake completes.
    task automatic push(input logic [1:0] op, input logic [11:0] arg);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        while (!cmd_ready && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) chk("push_timeout", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Expect {bdir,bc1,din} == exp for n consecutive ticks.
    task automatic phase(input string tag, input logic [9:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, 32'({bdir, bc1, din}), 32'(exp));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        step(); step(); step();
        rst_n = 1'b1;
        chk("rst_bus",   32'({bdir, bc1, din}), 32'd0);
        chk("rst_flags", 32'({busy, done, err}), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // Full write cycle to r7.
        push(2'b00, 12'h738);
        chk("w1_level", 32'(level), 32'd1);
        chk("w1_busy", 32'(busy), 32'd1);
        phase("w1_addr",  {2'b11, 8'h07}, 8);
        phase("w1_gap",   {2'b00, 8'h07}, 1);
        phase("w1_data",  {2'b10, 8'h38}, 8);
        phase("w1_recov", {2'b00, 8'h38}, 8);
        step();
        chk("w1_busy_fall", 32'(busy), 32'd0);

        // Same register twice: second write skips address phase.
        push(2'b00, 12'h012);
        phase("w2_addr",  {2'b11, 8'h00}, 8);
        phase("w2_gap",   {2'b00, 8'h00}, 1);
        phase("w2_data",  {2'b10, 8'h12}, 8);
        phase("w2_recov", {2'b00, 8'h12}, 8);
        step();
        push(2'b00, 12'h034);
        phase("w3_data",  {2'b10, 8'h34}, 8);
        phase("w3_recov", {2'b00, 8'h34}, 8);
        step();
        chk("w3_idle", 32'(busy), 32'd0);

        // WAIT 2 -> 32 inactive ticks, then a write to r5.
        push(2'b01, 12'h002);
        push(2'b00, 12'h5AA);
        chk("wait_level", 32'(level), 32'd1);
        chk("wait_first", 32'({bdir, bc1, din}), 32'({2'b00, 8'h34}));
        phase("wait_body", {2'b00, 8'h34}, 31);
        phase("wait_pop",  {2'b00, 8'h34}, 1);
        phase("w4_addr",   {2'b11, 8'h05}, 8);
        phase("w4_gap",    {2'b00, 8'h05}, 1);
        phase("w4_data",   {2'b10, 8'hAA}, 8);
        phase("w4_recov",  {2'b00, 8'hAA}, 8);
        step();

        // WAIT 0 -> no gap; same address goes straight to data.
        push(2'b01, 12'h000);
        push(2'b00, 12'h5BB);
        chk("wait0_idle", 32'({bdir, bc1}), 32'd0);
        phase("w5_data",  {2'b10, 8'hBB}, 8);
        phase("w5_recov", {2'b00, 8'hBB}, 8);
        wait_idle();

        // Fill the FIFO behind a WAIT and check back-pressure.
        push(2'b01, 12'h004);
        for (int i = 0; i < 8; i++) push(2'b00, 12'h220 + 12'(i));
        chk("full_level", 32'(level), 32'd8);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_arg   = 12'h299;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("full_hold", 32'({cmd_ready, level}), 32'({1'b0, 4'd8}));
        end
        push(2'b00, 12'h299);
        chk("refill_level", 32'(level), 32'd8);
        wait_idle();
        chk("drain_din", 32'(din), 32'h99);
        chk("drain_level", 32'(level), 32'd0);

        // Reserved op sets err and issues no bus cycle.
        push(2'b11, 12'h123);
        step();
        chk("rsv_err", 32'({err, busy, bdir, bc1}), 32'b1000);

        // END is terminal; later commands queue but are not popped.
        push(2'b10, 12'h000);
        step();
        chk("end_done", 32'({done, busy}), 32'b11);
        push(2'b00, 12'h411);
        for (int i = 0; i < 5; i++) step();
        chk("end_level", 32'(level), 32'd1);
        chk("end_bus", 32'({bdir, bc1, done}), 32'b001);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_flags", 32'({done, err, busy}), 32'd0);
        chk("rst2_level", 32'({cmd_ready, level}), 32'({1'b1, 4'd0}));

        // clk_en low freezes the address phase.
        push(2'b00, 12'h344);
        phase("ce_addr0", {2'b11, 8'h03}, 1);
        clk_en = 1'b0;
        phase("ce_frozen", {2'b11, 8'h03}, 5);
        clk_en = 1'b1;
        phase("ce_addr",  {2'b11, 8'h03}, 7);
        phase("ce_gap",   {2'b00, 8'h03}, 1);
        phase("ce_data",  {2'b10, 8'h44}, 3);

        // Reset during DATA abandons the write and flushes the FIFO.
        push(2'b00, 12'h666);
        chk("mid_level", 32'(level), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_bus", 32'({bdir, bc1, din}), 32'd0);
        chk("mid_rst_state", 32'({level, done, err, busy}), 32'd0);

        // Last address is invalid after reset: r3 takes the address phase again.
        push(2'b00, 12'h344);
        phase("post_addr",  {2'b11, 8'h03}, 8);
        phase("post_gap",   {2'b00, 8'h03}, 1);
        phase("post_data",  {2'b10, 8'h44}, 8);
        phase("post_recov", {2'b00, 8'h44}, 8);
        wait_idle();

`ifdef JT49_SEQ_SHADOW_EN
        push(2'b00, 12'h155);
        phase("sh_addr", {2'b11, 8'h01}, 8);
        wait_idle();
        push(2'b00, 12'h155);
        step();
        chk("sh_dropped", 32'({busy, bdir, bc1}), 32'd0);
        push(2'b00, 12'hD0E);
        phase("sh_env1", {2'b11, 8'h0D}, 8);
        wait_idle();
        push(2'b00, 12'hD0E);
        phase("sh_env2", {2'b10, 8'h0E}, 8);
        wait_idle();
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
